// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit control FSM driving a 4:1 line mux
// Optional UART_TX_BACK2BACK_EN: accept a new word in STOP for gapless frames.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DATA_VALID,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  load;

  // A word is only accepted where a new frame may legally begin.
`ifdef UART_TX_BACK2BACK_EN
  assign load = DATA_VALID && ((state == IDLE) || (state == STOP));
`else
  assign load = DATA_VALID && (state == IDLE);
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Frame settings are frozen at load so the inputs may change mid-frame.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      data_q   <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      if (load) begin
        data_q   <= P_DATA;
        par_en_q <= PAR_EN;
        par_bit  <= (^P_DATA) ^ PAR_TYP;
      end
      if (state == DATA) begin
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load) next_state = START;
      START:   next_state = DATA;
      DATA:    if (bit_cnt == LAST_BIT) next_state = par_en_q ? PARITY : STOP;
      PARITY:  next_state = STOP;
      STOP:    next_state = load ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mux_sel  = 2'b01;
    busy     = 1'b0;
    done     = 1'b0;
    ser_data = 1'b0;
    case (state)
      START: begin
        mux_sel = 2'b00;
        busy    = 1'b1;
      end
      DATA: begin
        mux_sel  = 2'b10;
        busy     = 1'b1;
        ser_data = data_q[bit_cnt];
      end
      PARITY: begin
        mux_sel = 2'b11;
        busy    = 1'b1;
      end
      STOP: begin
        mux_sel = 2'b01;
        busy    = 1'b1;
        done    = 1'b1;
      end
      default: begin
        mux_sel = 2'b01;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb/tb_uart_tx_fsm.sv - scoreboard bench for uart_tx_fsm
module tb_uart_tx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       DATA_VALID = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [1:0] mux_sel;
  logic       ser_data;
  logic       par_bit;
  logic       busy;
  logic       done;

  uart_tx_fsm #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .DATA_VALID(DATA_VALID), .P_DATA(P_DATA),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .mux_sel(mux_sel),
    .ser_data(ser_data), .par_bit(par_bit), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [1:0] mux;
    logic       busy;
    logic       done;
    logic       chk_ser;
    logic       ser;
    logic       chk_par;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  logic mon_en = 1'b0;

  function automatic exp_t mk(string name, logic [1:0] mux, logic b, logic d,
                              logic cs, logic s, logic cp, logic p);
    exp_t e;
    e.name = name; e.mux = mux; e.busy = b; e.done = d;
    e.chk_ser = cs; e.ser = s; e.chk_par = cp; e.par = p;
    return e;
  endfunction

  task automatic push_idle();
    exp_q.push_back(mk("idle", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Expected line sequence for one frame; par is the hand-computed parity.
  task automatic push_frame(input logic [7:0] d, input logic pe, input logic par);
    exp_q.push_back(mk("start", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, par));
    for (int i = 0; i < 8; i++)
      exp_q.push_back(mk($sformatf("data%0d", i), 2'b10, 1'b1, 1'b0, 1'b1, d[i], 1'b1, par));
    if (pe) exp_q.push_back(mk("parity", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, par));
    exp_q.push_back(mk("stop", 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, par));
  endtask

  always @(negedge CLK) begin
    exp_t e;
    cycle++;
    if (mon_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk("idle", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (mux_sel !== e.mux || busy !== e.busy || done !== e.done ||
          (e.chk_ser && ser_data !== e.ser) || (e.chk_par && par_bit !== e.par)) begin
        errors++;
        $display("FAIL %s cycle %0d: got mux=%b busy=%b done=%b ser=%b par=%b want mux=%b busy=%b done=%b ser=%b par=%b",
                 e.name, cycle, mux_sel, busy, done, ser_data, par_bit,
                 e.mux, e.busy, e.done, e.ser, e.par);
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left want 0", exp_q.size());
    end
  endtask

  // Single DATA_VALID pulse from IDLE; optionally changes P_DATA mid-frame.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic par, input bit corrupt);
    @(posedge CLK); #1;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    push_idle();
    push_frame(d, pe, par);
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    if (corrupt) begin
      repeat (3) @(posedge CLK);
      #1;
      P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt;
    end
    wait_drain();
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    RST = 1'b0;
    @(posedge CLK); #1;
    mon_en = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (par_bit !== 1'b0 || ser_data !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got par=%b ser=%b want par=0 ser=0", par_bit, ser_data);
    end
    repeat (4) @(posedge CLK);

    send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during the 4th data bit aborts the frame.
    @(posedge CLK); #1;
    P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    push_idle();
    exp_q.push_back(mk("start", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++)
      exp_q.push_back(mk($sformatf("abort_data%0d", i), 2'b10, 1'b1, 1'b0, 1'b1, P_DATA[i], 1'b0, 1'b0));
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    wait_drain();
    repeat (2) @(posedge CLK);
    send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);

    // DATA_VALID held high across two frames.
    @(posedge CLK); #1;
    P_DATA = 8'h55; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    push_idle();
    push_frame(8'h55, 1'b1, 1'b0);
`ifndef UART_TX_BACK2BACK_EN
    push_idle();
`endif
    push_frame(8'h07, 1'b1, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    P_DATA = 8'h07;
`ifdef UART_TX_BACK2BACK_EN
    repeat (10) @(posedge CLK);
`else
    repeat (11) @(posedge CLK);
`endif
    #1;
    DATA_VALID = 1'b0;
    wait_drain();
    repeat (3) @(posedge CLK);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
